// File: rtl/time_pkg.sv
`default_nettype none
// time_pkg: limits, digit/segment types and the seven-segment encoder shared by the time display core.
package time_pkg;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [5:0] SEC_MAX    = 6'd59;
   localparam logic [5:0] MIN_MAX    = 6'd59;
   localparam logic [4:0] HR_MAX     = 5'd23;
   localparam int         NUM_DIGITS = 6;

   typedef logic [2:0] digit_idx_t;
   typedef logic [3:0] bcd_t;

   // Active-low segments, bit0 = a .. bit6 = g; non-decimal codes blank the digit.
   function automatic logic [6:0] seg_encode(input bcd_t i_bcd);
      logic [6:0] w_seg;
      case (i_bcd)
         4'd0:    w_seg = 7'h40;
         4'd1:    w_seg = 7'h79;
         4'd2:    w_seg = 7'h24;
         4'd3:    w_seg = 7'h30;
         4'd4:    w_seg = 7'h19;
         4'd5:    w_seg = 7'h12;
         4'd6:    w_seg = 7'h02;
         4'd7:    w_seg = 7'h78;
         4'd8:    w_seg = 7'h00;
         4'd9:    w_seg = 7'h10;
         default: w_seg = SEG_BLANK;
      endcase
      return w_seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/time_display_core_bin2bcd6.sv
`default_nettype none
// bin2bcd6: 6-bit binary (0..63) to tens/ones BCD digits.
module bin2bcd6
   import time_pkg::*;
(
   input  logic [5:0] i_bin,
   output bcd_t       o_tens,
   output bcd_t       o_ones
);

   assign o_tens = 4'(i_bin / 6'd10);
   assign o_ones = 4'(i_bin % 6'd10);

endmodule
`default_nettype wire

// File: rtl/time_display_core.sv
`default_nettype none
// time_display_core: minutes/hours keeping plus a six-digit multiplexed seven-segment scanner.
// Optional macro HOUR12_EN selects 12-hour digits and drives the pm indicator.
module time_display_core
   import time_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [5:0] sec_in,
   input  logic       sec_cout,
   input  logic       set_min,
   input  logic       set_hr,
   output logic [5:0] minutes,
   output logic [4:0] hours,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       pm
);

   localparam int            CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [4:0]    HR_MOD   = HR_MAX + 5'd1;

   logic [5:0]    r_min;
   logic [4:0]    r_hr;
   logic [CW-1:0] r_cnt;
   digit_idx_t    r_dig;
   logic [6:0]    r_seg;
   logic [5:0]    r_an;

   logic       w_min_wrap, w_min_step, w_hr_carry;
   logic [5:0] w_min_nxt;
   logic [4:0] w_hr_sum, w_hr_nxt;
   logic [5:0] w_sec_disp;
   logic [4:0] w_hr_disp;
   logic       w_pm;
   bcd_t       w_sec_t, w_sec_o, w_min_t, w_min_o, w_hr_t, w_hr_o, w_bcd;

   // sec_cout absorbs a coincident set_min, but set_hr always adds on top of any carry.
   assign w_min_wrap = (r_min == MIN_MAX);
   assign w_min_step = sec_cout | set_min;
   assign w_hr_carry = sec_cout & w_min_wrap;
   assign w_min_nxt  = !w_min_step ? r_min : (w_min_wrap ? 6'd0 : r_min + 6'd1);
   assign w_hr_sum   = r_hr + {4'd0, w_hr_carry} + {4'd0, set_hr};
   assign w_hr_nxt   = (w_hr_sum > HR_MAX) ? w_hr_sum - HR_MOD : w_hr_sum;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_min <= 6'd0;
         r_hr  <= 5'd0;
      end else begin
         r_min <= w_min_nxt;
         r_hr  <= w_hr_nxt;
      end
   end

   assign w_sec_disp = (sec_in > SEC_MAX) ? 6'd0 : sec_in;

`ifdef HOUR12_EN
   assign w_hr_disp = (r_hr == 5'd0)  ? 5'd12 :
                      (r_hr > 5'd12)  ? r_hr - 5'd12 : r_hr;
   assign w_pm      = (r_hr >= 5'd12);
`else
   assign w_hr_disp = r_hr;
   assign w_pm      = 1'b0;
`endif

   bin2bcd6 u_sec_bcd (.i_bin(w_sec_disp),        .o_tens(w_sec_t), .o_ones(w_sec_o));
   bin2bcd6 u_min_bcd (.i_bin(r_min),             .o_tens(w_min_t), .o_ones(w_min_o));
   bin2bcd6 u_hr_bcd  (.i_bin({1'b0, w_hr_disp}), .o_tens(w_hr_t),  .o_ones(w_hr_o));

   always_comb begin
      w_bcd = 4'hF;
      case (r_dig)
         3'd0:    w_bcd = w_sec_o;
         3'd1:    w_bcd = w_sec_t;
         3'd2:    w_bcd = w_min_o;
         3'd3:    w_bcd = w_min_t;
         3'd4:    w_bcd = w_hr_o;
         3'd5:    w_bcd = w_hr_t;
         default: w_bcd = 4'hF;
      endcase
   end

   // seg/an are registered from the current index, so they trail the index change by one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
         r_dig <= 3'd0;
         r_seg <= SEG_BLANK;
         r_an  <= 6'h3F;
      end else begin
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_dig <= (r_dig == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_dig + 3'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_seg <= seg_encode(w_bcd);
         r_an  <= ~(6'b000001 << r_dig);
      end
   end

   assign minutes = r_min;
   assign hours   = r_hr;
   assign seg     = r_seg;
   assign an      = r_an;
   assign pm      = w_pm;

endmodule
`default_nettype wire
